// File: rtl/operand_fetch_stage_pkg.sv
// Shared definitions for the operand-fetch stage.
//   opf_state_e : fetch sequencer states (IDLE -> ISSUE -> CAPTURE -> HOLD)
//   ZERO_REG    : architectural x0 index
//   port_live() : true when a source operand must be fetched from the register file
package operand_fetch_stage_pkg;

    typedef enum logic [1:0] {
        OPF_IDLE    = 2'd0,
        OPF_ISSUE   = 2'd1,
        OPF_CAPTURE = 2'd2,
        OPF_HOLD    = 2'd3
    } opf_state_e;

    localparam logic [4:0] ZERO_REG = 5'd0;

    // x0 is writable in the register file, so it is never read; it is forced to zero instead.
    function automatic logic port_live(input logic use_rs, input logic [4:0] idx);
        return use_rs && (idx != ZERO_REG);
    endfunction

endpackage

// File: rtl/operand_fetch_stage_operand_capture.sv
// opf_operand_capture: one 32-bit source-operand latch.
//   clk, reset   : clock, synchronous active-high reset (operand cleared)
//   issue_en     : stage is in ISSUE; operand preset to bypass data or zero
//   bypass_hit   : writeback supplies this operand in the ISSUE cycle
//   bypass_data  : writeback data
//   capture_en   : stage is in CAPTURE; registered rf data is valid
//   live         : operand is used and not x0
//   rf_dout      : registered register-file read data
//   operand      : held operand value
module opf_operand_capture (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_en,
    input  logic        bypass_hit,
    input  logic [31:0] bypass_data,
    input  logic        capture_en,
    input  logic        live,
    input  logic [31:0] rf_dout,
    output logic [31:0] operand
);

    // Remembers that the operand came from writeback, so CAPTURE must not overwrite it.
    logic bypassed;

    always_ff @(posedge clk) begin
        if (reset) begin
            operand  <= '0;
            bypassed <= 1'b0;
        end else if (issue_en) begin
            operand  <= bypass_hit ? bypass_data : '0;
            bypassed <= bypass_hit;
        end else if (capture_en && live && !bypassed) begin
            operand  <= rf_dout;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: single-entry operand fetch between decoder and execute.
// Accepts a decoded instruction, reads rs1/rs2 through register-file ports p0/p1,
// retries reads suppressed by rf_conflict, forces x0/unused operands to zero and
// presents the operand bundle to execute with a valid/ready handshake.
//   dec_*        : decoder handshake and instruction fields
//   rf_*_p0/p1   : register-file read ports (data registered, valid the cycle after the read)
//   rf_conflict  : register-file read/write conflict, reads this cycle suppressed
//   wb_*         : writeback mirror (used only with bypass enabled)
//   ex_*         : execute handshake and operand bundle
//   err_retry    : sticky, conflict retries exceeded MAX_RETRY
// Build option: define OPF_WB_BYPASS_EN to take matching writeback data directly in
// ISSUE instead of reading the port; the stage then ignores rf_conflict.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int unsigned CTRL_W    = 16,
    parameter int unsigned MAX_RETRY = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [4:0]        dec_rs1,
    input  logic [4:0]        dec_rs2,
    input  logic              dec_use_rs1,
    input  logic              dec_use_rs2,
    input  logic [4:0]        dec_rd,
    input  logic [31:0]       dec_imm,
    input  logic [CTRL_W-1:0] dec_ctrl,
    output logic [4:0]        rf_addr_p0,
    output logic              rf_re_p0,
    input  logic [31:0]       rf_dout_p0,
    output logic [4:0]        rf_addr_p1,
    output logic              rf_re_p1,
    input  logic [31:0]       rf_dout_p1,
    input  logic              rf_conflict,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [31:0]       wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [31:0]       ex_rs1_val,
    output logic [31:0]       ex_rs2_val,
    output logic [4:0]        ex_rd,
    output logic [31:0]       ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              err_retry
);

    localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);

    opf_state_e  state, state_nxt;
    logic [4:0]  rs1_q, rs2_q;
    logic        use_rs1_q, use_rs2_q;
    logic [7:0]  retry_cnt;
    logic        live0, live1;
    logic        bypass0, bypass1;
    logic        read0, read1;
    logic        conflict_eff;
    logic        accept;
    logic        issue_en, capture_en;

    assign live0 = port_live(use_rs1_q, rs1_q);
    assign live1 = port_live(use_rs2_q, rs2_q);

`ifdef OPF_WB_BYPASS_EN
    assign bypass0      = live0 && wb_we && (wb_addr == rs1_q);
    assign bypass1      = live1 && wb_we && (wb_addr == rs2_q);
    assign conflict_eff = 1'b0;
    logic unused_conflict;
    assign unused_conflict = rf_conflict;
`else
    assign bypass0      = 1'b0;
    assign bypass1      = 1'b0;
    assign conflict_eff = rf_conflict;
    logic unused_wb;
    assign unused_wb = ^{wb_we, wb_addr, wb_data};
`endif

    assign read0      = live0 && !bypass0;
    assign read1      = live1 && !bypass1;
    assign rf_addr_p0 = rs1_q;
    assign rf_addr_p1 = rs2_q;
    assign accept     = dec_valid && dec_ready;

    always_comb begin
        state_nxt  = state;
        dec_ready  = 1'b0;
        rf_re_p0   = 1'b0;
        rf_re_p1   = 1'b0;
        ex_valid   = 1'b0;
        issue_en   = 1'b0;
        capture_en = 1'b0;
        case (state)
            OPF_IDLE: begin
                dec_ready = 1'b1;
                if (dec_valid) state_nxt = OPF_ISSUE;
            end
            OPF_ISSUE: begin
                rf_re_p0 = read0;
                rf_re_p1 = read1;
                issue_en = 1'b1;
                // Nothing to read: operands are already final (zero or bypassed).
                if (!read0 && !read1)  state_nxt = OPF_HOLD;
                else if (!conflict_eff) state_nxt = OPF_CAPTURE;
            end
            OPF_CAPTURE: begin
                capture_en = 1'b1;
                state_nxt  = OPF_HOLD;
            end
            OPF_HOLD: begin
                ex_valid  = 1'b1;
                dec_ready = ex_ready;
                if (ex_ready) state_nxt = dec_valid ? OPF_ISSUE : OPF_IDLE;
            end
            default: state_nxt = OPF_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= OPF_IDLE;
            rs1_q     <= '0;
            rs2_q     <= '0;
            use_rs1_q <= 1'b0;
            use_rs2_q <= 1'b0;
            ex_rd     <= '0;
            ex_imm    <= '0;
            ex_ctrl   <= '0;
            retry_cnt <= '0;
            err_retry <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rs1_q     <= dec_rs1;
                rs2_q     <= dec_rs2;
                use_rs1_q <= dec_use_rs1;
                use_rs2_q <= dec_use_rs2;
                ex_rd     <= dec_rd;
                ex_imm    <= dec_imm;
                ex_ctrl   <= dec_ctrl;
            end
            // Counter saturates at the limit; a further conflict flags the error
            // while retrying continues.
            if (state == OPF_ISSUE && (read0 || read1) && conflict_eff) begin
                if (retry_cnt == RETRY_LIMIT) err_retry <= 1'b1;
                else                          retry_cnt <= retry_cnt + 8'd1;
            end else begin
                retry_cnt <= '0;
            end
        end
    end

    opf_operand_capture u_cap_rs1 (
        .clk         (clk),
        .reset       (reset),
        .issue_en    (issue_en),
        .bypass_hit  (bypass0),
        .bypass_data (wb_data),
        .capture_en  (capture_en),
        .live        (live0),
        .rf_dout     (rf_dout_p0),
        .operand     (ex_rs1_val)
    );

    opf_operand_capture u_cap_rs2 (
        .clk         (clk),
        .reset       (reset),
        .issue_en    (issue_en),
        .bypass_hit  (bypass1),
        .bypass_data (wb_data),
        .capture_en  (capture_en),
        .live        (live1),
        .rf_dout     (rf_dout_p1),
        .operand     (ex_rs2_val)
    );

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage (default build, bypass disabled).
// A behavioural register file supplies registered read data; expected operands and
// latencies come from the architectural rules (x0/unused read as zero, one cycle per
// conflict on top of the three-cycle fetch).
module tb_operand_fetch_stage;

    localparam int CTRL_W    = 16;
    localparam int MAX_RETRY = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              dec_valid, dec_ready;
    logic [4:0]        dec_rs1, dec_rs2, dec_rd;
    logic              dec_use_rs1, dec_use_rs2;
    logic [31:0]       dec_imm;
    logic [CTRL_W-1:0] dec_ctrl;
    logic [4:0]        rf_addr_p0, rf_addr_p1;
    logic              rf_re_p0, rf_re_p1;
    logic [31:0]       rf_dout_p0, rf_dout_p1;
    logic              rf_conflict;
    logic              wb_we;
    logic [4:0]        wb_addr;
    logic [31:0]       wb_data;
    logic              ex_valid, ex_ready;
    logic [31:0]       ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]        ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              err_retry;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_fetch_stage #(.CTRL_W(CTRL_W), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .dec_rd(dec_rd), .dec_imm(dec_imm), .dec_ctrl(dec_ctrl),
        .rf_addr_p0(rf_addr_p0), .rf_re_p0(rf_re_p0), .rf_dout_p0(rf_dout_p0),
        .rf_addr_p1(rf_addr_p1), .rf_re_p1(rf_re_p1), .rf_dout_p1(rf_dout_p1),
        .rf_conflict(rf_conflict),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .err_retry(err_retry)
    );

    // Register file: registered read data, garbage when no accepted read.
    logic [31:0] rf [32];
    always @(posedge clk) begin
        rf_dout_p0 <= (rf_re_p0 && !rf_conflict) ? rf[rf_addr_p0] : $urandom();
        rf_dout_p1 <= (rf_re_p1 && !rf_conflict) ? rf[rf_addr_p1] : $urandom();
        if (wb_we) rf[wb_addr] <= wb_data;
    end

    function automatic logic [31:0] exp_op(input logic u, input logic [4:0] idx);
        return (u && idx != 5'd0) ? rf[idx] : 32'h0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1'b1; wb_addr = a; wb_data = d;
        step();
        wb_we = 1'b0;
    endtask

    task automatic send(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic [31:0] imm,
                        input logic [CTRL_W-1:0] ctrl);
        dec_valid = 1'b1; dec_rs1 = rs1; dec_rs2 = rs2; dec_use_rs1 = u1; dec_use_rs2 = u2;
        dec_rd = rd; dec_imm = imm; dec_ctrl = ctrl;
        step();
        dec_valid = 1'b0;
    endtask

    // Sends one instruction from IDLE, drives nconf conflict cycles, waits for ex_valid.
    // lat = cycle index (accept edge ends cycle 0) at which ex_valid is seen, -1 on timeout.
    task automatic run_one(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                           input logic u2, input logic [4:0] rd, input logic [31:0] imm,
                           input logic [CTRL_W-1:0] ctrl, input int nconf,
                           output int lat, output int re0, output int re1);
        int cyc;
        send(rs1, rs2, u1, u2, rd, imm, ctrl);
        cyc = 1; re0 = 0; re1 = 0;
        while (!ex_valid && cyc < 40) begin
            if (rf_re_p0) re0++;
            if (rf_re_p1) re1++;
            rf_conflict = (cyc <= nconf);
            step();
            cyc++;
        end
        rf_conflict = 1'b0;
        lat = ex_valid ? cyc : -1;
    endtask

    task automatic release_ex();
        ex_ready = 1'b1;
        step();
        ex_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_use_rs1 = 1'b0;
        dec_use_rs2 = 1'b0; dec_rd = '0; dec_imm = '0; dec_ctrl = '0; rf_conflict = 1'b0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0; ex_ready = 1'b0;
        step();
        for (int i = 0; i < 32; i++) wb_write(5'(i), $urandom());
        reset = 1'b0;
        step();
        checks++;
        if ({ex_valid, dec_ready, rf_re_p0, rf_re_p1, err_retry} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_ctrl: got v/rdy/re0/re1/err=%b required 01000",
                     {ex_valid, dec_ready, rf_re_p0, rf_re_p1, err_retry});
        end
        checks++;
        if ({ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_ctrl} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h %h required all zero",
                     ex_rs1_val, ex_rs2_val, ex_imm, ex_rd, ex_ctrl);
        end
    endtask

    task automatic test_basic();
        wb_write(5'd5, 32'hDEAD_BEEF);
        wb_write(5'd6, 32'h0000_1234);
        send(5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 32'h55AA_0001, 16'hBEEF);
        checks++;
        if ({rf_re_p0, rf_re_p1, rf_addr_p0, rf_addr_p1, ex_valid, dec_ready} !== {2'b11, 5'd5, 5'd6, 2'b00}) begin
            errors++;
            $display("FAIL basic_issue: got re=%b%b a0=%0d a1=%0d v=%b rdy=%b required re=11 a0=5 a1=6 v=0 rdy=0",
                     rf_re_p0, rf_re_p1, rf_addr_p0, rf_addr_p1, ex_valid, dec_ready);
        end
        step();
        checks++;
        if ({rf_re_p0, rf_re_p1, ex_valid, dec_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL basic_capture: got re/v/rdy=%b required 0000",
                     {rf_re_p0, rf_re_p1, ex_valid, dec_ready});
        end
        step();
        checks++;
        if ({ex_valid, ex_rs1_val, ex_rs2_val, ex_rd, ex_imm, ex_ctrl} !==
            {1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 5'd7, 32'h55AA_0001, 16'hBEEF}) begin
            errors++;
            $display("FAIL basic_hold: got v=%b %h %h rd=%0d %h %h required 1 deadbeef 00001234 7 55aa0001 beef",
                     ex_valid, ex_rs1_val, ex_rs2_val, ex_rd, ex_imm, ex_ctrl);
        end
        release_ex();
        checks++;
        if ({ex_valid, dec_ready} !== 2'b01) begin
            errors++;
            $display("FAIL basic_idle: got v/rdy=%b required 01", {ex_valid, dec_ready});
        end
    endtask

    task automatic test_conflict();
        int lat, re0, re1;
        run_one(5'd5, 5'd6, 1'b1, 1'b1, 5'd3, 32'h1, 16'h2, 2, lat, re0, re1);
        checks++;
        if (lat != 5 || re0 != 3 || re1 != 3) begin
            errors++;
            $display("FAIL conflict_timing: got lat=%0d re0=%0d re1=%0d required 5 3 3", lat, re0, re1);
        end
        checks++;
        if ({ex_rs1_val, ex_rs2_val, err_retry} !== {32'hDEAD_BEEF, 32'h0000_1234, 1'b0}) begin
            errors++;
            $display("FAIL conflict_vals: got %h %h err=%b required deadbeef 00001234 0",
                     ex_rs1_val, ex_rs2_val, err_retry);
        end
        release_ex();
    endtask

    task automatic test_x0();
        int lat, re0, re1;
        wb_write(5'd0, 32'hFFFF_FFFF);
        run_one(5'd0, 5'd6, 1'b1, 1'b1, 5'd1, 32'h0, 16'h0, 0, lat, re0, re1);
        checks++;
        if (lat != 3 || re0 != 0 || re1 != 1 || ex_rs1_val !== 32'h0 || ex_rs2_val !== 32'h1234) begin
            errors++;
            $display("FAIL x0_rs1: got lat=%0d re0=%0d re1=%0d %h %h required 3 0 1 00000000 00001234",
                     lat, re0, re1, ex_rs1_val, ex_rs2_val);
        end
        release_ex();
        run_one(5'd0, 5'd0, 1'b1, 1'b1, 5'd2, 32'h0, 16'h0, 0, lat, re0, re1);
        checks++;
        if (lat != 2 || re0 != 0 || re1 != 0 || ex_rs1_val !== 32'h0 || ex_rs2_val !== 32'h0) begin
            errors++;
            $display("FAIL x0_both: got lat=%0d re0=%0d re1=%0d %h %h required 2 0 0 0 0",
                     lat, re0, re1, ex_rs1_val, ex_rs2_val);
        end
        release_ex();
    endtask

    task automatic test_back_to_back();
        int lat, re0, re1;
        run_one(5'd5, 5'd6, 1'b1, 1'b1, 5'd9, 32'hA5A5_0009, 16'h0C0C, 0, lat, re0, re1);
        dec_rs1 = 5'd6; dec_rs2 = 5'd5; dec_use_rs1 = 1'b1; dec_use_rs2 = 1'b1;
        dec_rd = 5'd10; dec_imm = 32'h0000_0010; dec_ctrl = 16'h1010;
        dec_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({ex_valid, dec_ready, ex_rs1_val, ex_rs2_val, ex_rd, ex_imm, ex_ctrl} !==
                {2'b10, 32'hDEAD_BEEF, 32'h0000_1234, 5'd9, 32'hA5A5_0009, 16'h0C0C}) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got v=%b rdy=%b %h %h %0d %h %h required 1 0 deadbeef 00001234 9 a5a50009 0c0c",
                         i, ex_valid, dec_ready, ex_rs1_val, ex_rs2_val, ex_rd, ex_imm, ex_ctrl);
            end
            step();
        end
        ex_ready = 1'b1;
        #1;
        checks++;
        if (dec_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: got %b required 1", dec_ready);
        end
        step();
        dec_valid = 1'b0; ex_ready = 1'b0;
        checks++;
        if ({ex_valid, rf_re_p0, rf_re_p1, rf_addr_p0, rf_addr_p1} !== {3'b011, 5'd6, 5'd5}) begin
            errors++;
            $display("FAIL b2b_issue: got v=%b re=%b%b a0=%0d a1=%0d required 0 11 6 5",
                     ex_valid, rf_re_p0, rf_re_p1, rf_addr_p0, rf_addr_p1);
        end
        step();
        step();
        checks++;
        if ({ex_valid, ex_rs1_val, ex_rs2_val, ex_rd, ex_ctrl} !==
            {1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 5'd10, 16'h1010}) begin
            errors++;
            $display("FAIL b2b_hold: got v=%b %h %h %0d %h required 1 00001234 deadbeef 10 1010",
                     ex_valid, ex_rs1_val, ex_rs2_val, ex_rd, ex_ctrl);
        end
        release_ex();
    endtask

    task automatic test_retry_err();
        int lat, re0, re1;
        checks++;
        if (err_retry !== 1'b0) begin
            errors++;
            $display("FAIL retry_pre: got err=%b required 0", err_retry);
        end
        run_one(5'd5, 5'd6, 1'b1, 1'b1, 5'd4, 32'h4, 16'h4, MAX_RETRY + 1, lat, re0, re1);
        checks++;
        if (lat != MAX_RETRY + 4 || re0 != MAX_RETRY + 2 || err_retry !== 1'b1 ||
            ex_rs1_val !== 32'hDEAD_BEEF || ex_rs2_val !== 32'h1234) begin
            errors++;
            $display("FAIL retry_err: got lat=%0d re0=%0d err=%b %h %h required %0d %0d 1 deadbeef 00001234",
                     lat, re0, err_retry, ex_rs1_val, ex_rs2_val, MAX_RETRY + 4, MAX_RETRY + 2);
        end
        release_ex();
        run_one(5'd6, 5'd5, 1'b1, 1'b0, 5'd4, 32'h4, 16'h4, 0, lat, re0, re1);
        checks++;
        if (lat != 3 || err_retry !== 1'b1 || ex_rs2_val !== 32'h0) begin
            errors++;
            $display("FAIL retry_sticky: got lat=%0d err=%b rs2=%h required 3 1 0", lat, err_retry, ex_rs2_val);
        end
        release_ex();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        send(5'd5, 5'd6, 1'b1, 1'b1, 5'd8, 32'h8, 16'h8);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({ex_valid, dec_ready, err_retry} !== 3'b010 || ex_rs1_val !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: got v/rdy/err=%b rs1=%h required 010 0",
                     {ex_valid, dec_ready, err_retry}, ex_rs1_val);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            if (ex_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_drop: got %0d ex_valid cycles required 0", seen);
        end
    endtask

    task automatic test_random();
        int lat, re0, re1, nconf, hold, exp_lat;
        logic [4:0] rs1, rs2, rd;
        logic u1, u2, l1, l2;
        logic [31:0] imm, e1, e2;
        logic [CTRL_W-1:0] ctrl;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1) wb_write(5'($urandom_range(0, 31)), $urandom());
            rs1 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom());
            rs2 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom());
            u1 = 1'($urandom()); u2 = 1'($urandom());
            rd = 5'($urandom()); imm = $urandom(); ctrl = CTRL_W'($urandom());
            nconf = $urandom_range(0, 3);
            hold = $urandom_range(0, 2);
            e1 = exp_op(u1, rs1);
            e2 = exp_op(u2, rs2);
            l1 = u1 && rs1 != 5'd0;
            l2 = u2 && rs2 != 5'd0;
            exp_lat = (l1 || l2) ? 3 + nconf : 2;
            run_one(rs1, rs2, u1, u2, rd, imm, ctrl, nconf, lat, re0, re1);
            for (int h = 0; h < hold; h++) step();
            checks++;
            if (lat != exp_lat || re0 != (l1 ? nconf + 1 : 0) || re1 != (l2 ? nconf + 1 : 0)) begin
                errors++;
                $display("FAIL rand_timing[%0d]: got lat=%0d re0=%0d re1=%0d required lat=%0d re0=%0d re1=%0d",
                         it, lat, re0, re1, exp_lat, l1 ? nconf + 1 : 0, l2 ? nconf + 1 : 0);
            end
            checks++;
            if ({ex_valid, ex_rs1_val, ex_rs2_val, ex_rd, ex_imm, ex_ctrl} !== {1'b1, e1, e2, rd, imm, ctrl}) begin
                errors++;
                $display("FAIL rand_bundle[%0d]: got v=%b %h %h %0d %h %h required 1 %h %h %0d %h %h",
                         it, ex_valid, ex_rs1_val, ex_rs2_val, ex_rd, ex_imm, ex_ctrl, e1, e2, rd, imm, ctrl);
            end
            release_ex();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_conflict();
        test_x0();
        test_back_to_back();
        test_retry_err();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
